// File: rtl/zap_ram_fifo.sv
// zap_ram_fifo: first-word-fall-through FIFO built around a 1R+1W block-RAM
// array with a registered read. The array holds DEPTH entries and the output
// register holds one more, so total capacity is DEPTH+1. The read side
// prefetches from the array whenever the output register is empty or being
// popped, so the head entry is always waiting on o_rd_data.
module zap_ram_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  output logic                   o_full,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ZERO = '0;

  // Storage array; deliberately not reset so it maps onto block RAM.
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_ram_cnt;
  logic             r_dvalid;
  logic [WIDTH-1:0] r_dout;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_fetch;
  logic [AW:0]      w_ram_cnt_next;

  // Full and empty depend only on registered state, so neither enable has a
  // combinational path to any output.
  assign w_full  = (r_ram_cnt == CNT_FULL);
  assign w_push  = i_wr_en & ~w_full;
  assign w_pop   = i_rd_en & r_dvalid;
  // Refill the output register whenever it is empty or being vacated this
  // cycle. A fetch needs ram_cnt > 0 and a push needs ram_cnt < DEPTH, so the
  // read and write addresses never collide and no bypass path is required.
  assign w_fetch = (r_ram_cnt != CNT_ZERO) & (~r_dvalid | w_pop);

  // Array occupancy next value: +1 on push, -1 on fetch, unchanged on both.
  always_comb begin
    w_ram_cnt_next = r_ram_cnt;
    case ({w_push, w_fetch})
      2'b10:   w_ram_cnt_next = r_ram_cnt + 1'b1;
      2'b01:   w_ram_cnt_next = r_ram_cnt - 1'b1;
      default: w_ram_cnt_next = r_ram_cnt;
    endcase
  end

  // Array write port.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Registered array read feeding the output register; holds when idle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dout <= '0;
    end else if (w_fetch) begin
      r_dout <= r_mem[r_rd_ptr];
    end
  end

  // Pointers, occupancy count and output-register valid bit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_dvalid  <= 1'b0;
    end else begin
      r_ram_cnt <= w_ram_cnt_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_fetch) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_dvalid <= 1'b1;
      end else if (w_pop) begin
        r_dvalid <= 1'b0;
      end
    end
  end

  assign o_full    = w_full;
  assign o_empty   = ~r_dvalid;
  assign o_rd_data = r_dout;
  // ram_cnt == DEPTH implies dvalid, so this tops out at DEPTH+1 without wrap.
  assign o_level   = r_ram_cnt + {{AW{1'b0}}, r_dvalid};

endmodule

// File: doc/zap_ram_fifo.md
# zap_ram_fifo

Synchronous first-word-fall-through FIFO that acts as both writer and reader of a 1R+1W block-RAM array with a one-cycle registered read. The write side pushes into the array; the read side prefetches from it so the head entry is always presented on `o_rd_data` while `o_empty` is low. It is used for buffering in the cache and bus-interface paths, for example store buffers and fill queues.

## Interface
- `WIDTH`, default 32: data width in bits.
- `DEPTH`, default 16: array depth. Must be a power of two and at least 4. Total capacity is `DEPTH+1` entries: `DEPTH` in the array plus 1 in the output register.
- `i_clk`  in  1: clock. All state changes on its rising edge.
- `i_reset_n`  in  1: one clock; reset is asynchronous and active-low.
- `i_wr_en`  in  1: push request. Accepted only when `o_full`=0.
- `i_wr_data`  in  WIDTH: push data.
- `o_full`  out  1: no space available.
- `i_rd_en`  in  1: pop the head entry. Honoured only when `o_empty`=0.
- `o_rd_data`  out  WIDTH: head entry. Valid only while `o_empty`=0.
- `o_empty`  out  1: no head entry available.
- `o_level`  out  $clog2(DEPTH)+1: total entries held, equal to array count plus output-register valid bit.

## Operation
- **State:** `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap modulo DEPTH. `ram_cnt` ranges 0..DEPTH. `dvalid` is the output-register valid bit. `dout` is the registered array read data, held when no fetch occurs.
- **Push** (`push` = `i_wr_en` & !`o_full`):
  - write `array[wr_ptr]`;
  - increment `wr_ptr`.
- **Pop** (`pop` = `i_rd_en` & `dvalid`).
- **Fetch** (`fetch` = (`ram_cnt` != 0) & (!`dvalid` | `pop`)):
  - `dout` <= `array[rd_ptr]`;
  - increment `rd_ptr`;
  - `dvalid` <= 1.
- **`dvalid` when no fetch:** pop without fetch clears `dvalid`; otherwise `dvalid` holds.
- **`ram_cnt` next** = `ram_cnt` + `push` − `fetch`.
- **Outputs:**
  - `o_empty` = !`dvalid`;
  - `o_full` = (`ram_cnt` == DEPTH);
  - `o_rd_data` = `dout`;
  - `o_level` = `ram_cnt` + `dvalid`.
- **Invariant:** `ram_cnt` == DEPTH implies `dvalid`=1, so `o_full` is asserted exactly when `o_level` == DEPTH+1.
- **Address conflict:** fetch never reads the address being written in the same cycle. A fetch needs `ram_cnt` > 0, and a push needs `ram_cnt` < DEPTH, so `rd_ptr` != `wr_ptr` whenever both occur. No read-during-write bypass is required.
- **Misuse:**
  - push while full is dropped silently; no state changes;
  - pop while empty is ignored.
- **Simultaneous events:**
  - push and pop in the same cycle while full: the push is dropped, because `o_full` is evaluated on current state, and the pop proceeds;
  - push and pop while not full: both take effect, and `o_level` is unchanged when a fetch refills the output.
- **Reset (`i_reset_n` low), asynchronous:**
  - `wr_ptr`, `rd_ptr`, `ram_cnt`, `dvalid` go to 0;
  - `dout` goes to 0.
  - Array contents are not reset.
  - Reset asserted mid-operation discards all entries immediately.
- **Reset values of outputs:** `o_empty`=1, `o_full`=0, `o_level`=0, `o_rd_data`=0.

## Timing
- **Write-to-read latency into an empty FIFO:**
  - cycle t, push: `o_level`=1 after edge t;
  - cycle t+1: fetch issued, `o_empty` still 1;
  - from cycle t+2: `o_empty`=0 with the data on `o_rd_data`.
- **Throughput:** pop 1 entry per cycle sustained while `ram_cnt` > 0. The next head appears the cycle after the pop edge, with no bubble.
- **Draining:** a pop of the last entry (`ram_cnt`=0) sets `o_empty`=1 on the next cycle.
- **Output updates:** `o_full`, `o_empty` and `o_level` are all functions of registered state and change only on clock edges or on reset assertion.
- **Input paths:** there is no combinational path from `i_rd_en` or `i_wr_en` to any output.

## Test plan
- **Reset:** assert `i_reset_n`=0 mid-stream with 5 entries held, then release. Required: `o_empty`=1, `o_full`=0, `o_level`=0 and `o_rd_data`=0 immediately on assertion. The first push after release (data 0xA5A5A5A5) reads back as 0xA5A5A5A5.
- **Fill and overflow:** with DEPTH=16, push 0..16 on consecutive cycles with no pops. Required:
  - `o_empty`=0 two cycles after the first push;
  - `o_full`=1 after the 17th push, with `o_level`=17;
  - an 18th push (0xDEAD) is dropped;
  - draining returns 0..16 in order, with 0xDEAD absent.
- **Streaming:** push and pop every cycle for 100 cycles after priming 1 entry. Required: `o_level` stays 1 or 2, the data sequence is intact, and there are no bubbles.
- **Full plus simultaneous push and pop:** when full, drive push 0x55 and pop together. Required: the pop succeeds, 0x55 is dropped, `o_level`=16 and `o_full`=0. A next-cycle push of 0x66 is accepted.
- **Pointer wrap:** perform 40 push/pop pairs with an occupancy pattern of 3..DEPTH+1 so that both pointers wrap at least twice. Required: output equals the input order, with `o_level` matching a reference count every cycle.
- **Empty misuse:** pop at `o_empty`=1 for 3 cycles, then push 0x1. Required: `o_level` stays 0 throughout the pops, then 0x1 appears at t+2 and `o_level`=1.
